// File: rtl/pcs_tx_ordered_set_pkg.sv
// Shared constants for the 1000BASE-X PCS transmit ordered-set generator:
// xmit encodings, special/data octets, state encoding and config-set helpers.
package pcs_tx_ordered_set_pkg;

  localparam logic [2:0] XMIT_CONFIG = 3'b001;
  localparam logic [2:0] XMIT_IDLE   = 3'b010;
  localparam logic [2:0] XMIT_DATA   = 3'b100;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D16_2 = 8'h50;

  typedef enum logic [2:0] {
    ST_IDLE_K,
    ST_IDLE_D,
    ST_CFG,
    ST_SOP,
    ST_DATA,
    ST_EOP_T,
    ST_EOP_R1,
    ST_EOP_R2
  } tx_state_e;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_CONFIG,
    MODE_DATA
  } xmit_mode_e;

  // Anything that is not a clean one-hot CONFIG/DATA code behaves as IDLE.
  function automatic xmit_mode_e decode_xmit(input logic [2:0] xmit_code);
    xmit_mode_e mode;
    case (xmit_code)
      XMIT_CONFIG: mode = MODE_CONFIG;
      XMIT_DATA:   mode = MODE_DATA;
      XMIT_IDLE:   mode = MODE_IDLE;
      default:     mode = MODE_IDLE;
    endcase
    return mode;
  endfunction

  // Octet for slot idx of the 8-slot /C1/ /C2/ cycle; bit 2 selects /C2/.
  function automatic logic [7:0] cfg_octet(input logic [2:0] idx, input logic [15:0] cfg_word);
    logic [7:0] octet;
    case (idx[1:0])
      2'd0:    octet = K28_5;
      2'd1:    octet = idx[2] ? D2_2 : D21_5;
      2'd2:    octet = cfg_word[7:0];
      2'd3:    octet = cfg_word[15:8];
      default: octet = K28_5;
    endcase
    return octet;
  endfunction

endpackage

// File: rtl/pcs_tx_ordered_set_if.sv
// GMII transmit inputs and pre-8b/10b code-group outputs of the PCS transmit stage.
// master drives GMII (MAC side), slave is the PCS transmit block.
interface pcs_tx_ordered_set_if;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic [2:0] xmit;
  logic [7:0] tx_code_group;
  logic       tx_is_k;
  logic       tx_even;
  logic       transmitting;

  modport master (
    output TXD, TX_EN, TX_ER, xmit,
    input  tx_code_group, tx_is_k, tx_even, transmitting
  );

  modport slave (
    input  TXD, TX_EN, TX_ER, xmit,
    output tx_code_group, tx_is_k, tx_even, transmitting
  );
endinterface

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set generator: one registered code-group per GTX_CLK
// carrying /I2/, /C1/C2/, /S/ data /T/ /R/ and /V/ with even/odd slot alignment.
module pcs_tx_ordered_set
  import pcs_tx_ordered_set_pkg::*;
#(
  parameter logic [15:0] CFG_REG = 16'h0000,
  parameter logic [7:0]  IDLE_D  = D16_2
) (
  input logic                 GTX_CLK,
  input logic                 mr_main_reset,
  pcs_tx_ordered_set_if.slave gmii
);

  tx_state_e  state_r;
  logic [2:0] cfg_cnt_r;
  logic       tx_en_prev_r;
  logic       sop_pend_r;
  logic [7:0] code_r;
  logic       is_k_r;
  logic       even_r;
  logic       transmitting_r;

  xmit_mode_e mode_s;
  logic       next_even_s;
  logic       rising_s;
  logic       start_ok_s;
  logic       in_frame_s;
  logic [2:0] cfg_next_s;

  tx_state_e  bnd_state_s;
  logic [7:0] bnd_code_s;
  logic       bnd_k_s;
  logic       bnd_tx_s;
  logic [2:0] bnd_cnt_s;

  tx_state_e  state_s;
  logic [2:0] cfg_cnt_s;
  logic       sop_pend_s;
  logic [7:0] code_s;
  logic       is_k_s;
  logic       transmitting_s;

  // Input qualification shared by every state.
  always_comb begin
    mode_s      = decode_xmit(gmii.xmit);
    next_even_s = ~even_r;
    rising_s    = gmii.TX_EN & ~tx_en_prev_r;
    start_ok_s  = (mode_s == MODE_DATA) && gmii.TX_EN && (rising_s || sop_pend_r);
    in_frame_s  = (state_r == ST_SOP) || (state_r == ST_DATA);
    cfg_next_s  = cfg_cnt_r + 3'd1;
  end

  // Choice of the next ordered set at an even-slot boundary.
  always_comb begin
    bnd_state_s = ST_IDLE_K;
    bnd_code_s  = K28_5;
    bnd_k_s     = 1'b1;
    bnd_tx_s    = 1'b0;
    bnd_cnt_s   = 3'd0;
    if (start_ok_s) begin
      bnd_state_s = ST_SOP;
      bnd_code_s  = K27_7;
      bnd_tx_s    = 1'b1;
    end else if (mode_s == MODE_CONFIG) begin
      bnd_state_s = ST_CFG;
    end else begin
      bnd_state_s = ST_IDLE_K;
    end
  end

  // Next code-group and state.
  always_comb begin
    state_s        = state_r;
    cfg_cnt_s      = cfg_cnt_r;
    code_s         = K28_5;
    is_k_s         = 1'b1;
    transmitting_s = 1'b0;

    case (state_r)
      ST_IDLE_K: begin
        state_s = ST_IDLE_D;
        code_s  = IDLE_D;
        is_k_s  = 1'b0;
      end
      ST_CFG: begin
        if ((cfg_cnt_r[1:0] == 2'b11) && (mode_s != MODE_CONFIG)) begin
          state_s        = bnd_state_s;
          code_s         = bnd_code_s;
          is_k_s         = bnd_k_s;
          transmitting_s = bnd_tx_s;
          cfg_cnt_s      = bnd_cnt_s;
        end else begin
          cfg_cnt_s = cfg_next_s;
          code_s    = cfg_octet(cfg_next_s, CFG_REG);
          is_k_s    = (cfg_next_s[1:0] == 2'b00);
        end
      end
      ST_SOP, ST_DATA: begin
        transmitting_s = 1'b1;
        // Leaving DATA mode terminates the frame exactly like TX_EN falling.
        if ((mode_s != MODE_DATA) || !gmii.TX_EN) begin
          state_s = ST_EOP_T;
          code_s  = K29_7;
        end else if (gmii.TX_ER) begin
          state_s = ST_DATA;
          code_s  = K30_7;
        end else begin
          state_s = ST_DATA;
          code_s  = gmii.TXD;
          is_k_s  = 1'b0;
        end
      end
      ST_EOP_T: begin
        state_s = ST_EOP_R1;
        code_s  = K23_7;
      end
      ST_EOP_R1: begin
        if (even_r) begin
          state_s = ST_EOP_R2;
          code_s  = K23_7;
        end else begin
          state_s        = bnd_state_s;
          code_s         = bnd_code_s;
          is_k_s         = bnd_k_s;
          transmitting_s = bnd_tx_s;
          cfg_cnt_s      = bnd_cnt_s;
        end
      end
      ST_IDLE_D, ST_EOP_R2: begin
        state_s        = bnd_state_s;
        code_s         = bnd_code_s;
        is_k_s         = bnd_k_s;
        transmitting_s = bnd_tx_s;
        cfg_cnt_s      = bnd_cnt_s;
      end
      default: begin
        state_s   = ST_IDLE_K;
        cfg_cnt_s = 3'd0;
      end
    endcase
  end

  // A start seen on an odd slot is remembered only until the following even slot.
  always_comb begin
    if (next_even_s) begin
      sop_pend_s = 1'b0;
    end else if (!in_frame_s && (mode_s == MODE_DATA) && rising_s) begin
      sop_pend_s = 1'b1;
    end else begin
      sop_pend_s = sop_pend_r;
    end
  end

  // State and registered code-group outputs.
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_r        <= ST_IDLE_K;
      cfg_cnt_r      <= 3'd0;
      tx_en_prev_r   <= 1'b0;
      sop_pend_r     <= 1'b0;
      code_r         <= K28_5;
      is_k_r         <= 1'b1;
      even_r         <= 1'b1;
      transmitting_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      cfg_cnt_r      <= cfg_cnt_s;
      tx_en_prev_r   <= gmii.TX_EN;
      sop_pend_r     <= sop_pend_s;
      code_r         <= code_s;
      is_k_r         <= is_k_s;
      even_r         <= next_even_s;
      transmitting_r <= transmitting_s;
    end
  end

  assign gmii.tx_code_group = code_r;
  assign gmii.tx_is_k       = is_k_r;
  assign gmii.tx_even       = even_r;
  assign gmii.transmitting  = transmitting_r;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Randomized scoreboard bench for pcs_tx_ordered_set: an ordered-set level model predicts
// every code-group, a monitor compares each DUT output slot against the prediction.
module tb_pcs_tx_ordered_set;

  localparam logic [15:0] CFG = 16'h01A0;
  localparam logic [2:0]  X_CFG  = 3'b001;
  localparam logic [2:0]  X_IDLE = 3'b010;
  localparam logic [2:0]  X_DATA = 3'b100;

  logic GTX_CLK = 1'b0;
  logic mr_main_reset = 1'b1;

  pcs_tx_ordered_set_if bus ();

  pcs_tx_ordered_set #(.CFG_REG(CFG), .IDLE_D(8'h50)) dut (
    .GTX_CLK      (GTX_CLK),
    .mr_main_reset(mr_main_reset),
    .gmii         (bus)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  typedef struct packed {logic [7:0] o; logic k; logic t;} cg_t;
  typedef struct packed {logic [7:0] o; logic k; logic e; logic t;} exp_t;

  cg_t  set_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   slot_no = 0;

  bit m_even_next, m_in_frame, m_prev_en, m_pend, m_last_cfg, m_half;

  function automatic void model_reset();
    set_q.delete();
    exp_q.delete();
    set_q.push_back('{o: 8'h50, k: 1'b0, t: 1'b0});
    m_even_next = 1'b0;
    m_in_frame  = 1'b0;
    m_prev_en   = 1'b0;
    m_pend      = 1'b0;
    m_last_cfg  = 1'b0;
    m_half      = 1'b0;
  endfunction

  // Predict the code-group for the slot that the next rising edge produces.
  function automatic void model_step(input logic [7:0] txd, input logic en, input logic er,
                                     input logic [2:0] x);
    cg_t  c;
    exp_t e;
    bit is_data, is_cfg, rising;
    is_data = (x == X_DATA);
    is_cfg  = (x == X_CFG);
    rising  = en && !m_prev_en;
    if (m_in_frame) begin
      if (!is_data || !en) begin
        c = '{o: 8'hFD, k: 1'b1, t: 1'b1};
        set_q.push_back('{o: 8'hF7, k: 1'b1, t: 1'b0});
        if (!m_even_next) set_q.push_back('{o: 8'hF7, k: 1'b1, t: 1'b0});
        m_in_frame = 1'b0;
      end else if (er) begin
        c = '{o: 8'hFE, k: 1'b1, t: 1'b1};
      end else begin
        c = '{o: txd, k: 1'b0, t: 1'b1};
      end
    end else if (set_q.size() > 0) begin
      c = set_q.pop_front();
      if (!m_even_next && is_data && rising) m_pend = 1'b1;
    end else if (is_data && en && (rising || m_pend)) begin
      c = '{o: 8'hFB, k: 1'b1, t: 1'b1};
      m_in_frame = 1'b1;
      m_last_cfg = 1'b0;
    end else if (is_cfg) begin
      if (!m_last_cfg) m_half = 1'b0;
      set_q.push_back('{o: 8'hBC, k: 1'b1, t: 1'b0});
      set_q.push_back('{o: (m_half ? 8'h42 : 8'hB5), k: 1'b0, t: 1'b0});
      set_q.push_back('{o: CFG[7:0], k: 1'b0, t: 1'b0});
      set_q.push_back('{o: CFG[15:8], k: 1'b0, t: 1'b0});
      m_half     = !m_half;
      m_last_cfg = 1'b1;
      c = set_q.pop_front();
    end else begin
      m_last_cfg = 1'b0;
      c = '{o: 8'hBC, k: 1'b1, t: 1'b0};
      set_q.push_back('{o: 8'h50, k: 1'b0, t: 1'b0});
    end
    if (m_even_next) m_pend = 1'b0;
    e = '{o: c.o, k: c.k, e: m_even_next, t: c.t};
    exp_q.push_back(e);
    m_even_next = !m_even_next;
    m_prev_en   = en;
  endfunction

  task automatic drive_now(input logic [7:0] txd, input logic en, input logic er,
                           input logic [2:0] x);
    bus.TXD   = txd;
    bus.TX_EN = en;
    bus.TX_ER = er;
    bus.xmit  = x;
    model_step(txd, en, er, x);
  endtask

  task automatic drive(input logic [7:0] txd, input logic en, input logic er,
                       input logic [2:0] x);
    @(negedge GTX_CLK);
    drive_now(txd, en, er, x);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (bus.tx_code_group === 8'hBC && bus.tx_is_k === 1'b1 && bus.tx_even === 1'b1 &&
        bus.transmitting === 1'b0) begin
      passed++;
    end else begin
      $display("FAIL %s: got code=%02h k=%b even=%b tx=%b, want code=bc k=1 even=1 tx=0",
               tag, bus.tx_code_group, bus.tx_is_k, bus.tx_even, bus.transmitting);
    end
  endtask

  task automatic release_reset();
    @(negedge GTX_CLK);
    mr_main_reset = 1'b0;
    model_reset();
    drive_now(8'h00, 1'b0, 1'b0, X_IDLE);
  endtask

  task automatic do_reset();
    @(negedge GTX_CLK);
    mr_main_reset = 1'b1;
    bus.TX_EN = 1'b0;
    bus.TX_ER = 1'b0;
    #1;
    check_reset("reset_mid");
    repeat (2) @(negedge GTX_CLK);
    release_reset();
  endtask

  // Random gap, preamble/SFD/payload, optional /V/ octet, abort and reset points.
  task automatic send_frame(input int len, input int err_at, input int abort_at, input int rst_at);
    int gap;
    logic [2:0] x;
    gap = $urandom_range(1, 5);
    for (int i = 0; i < gap; i++)
      drive(8'($urandom), 1'b0, ($urandom_range(0, 3) == 0), X_DATA);
    x = X_DATA;
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      if (i == rst_at) begin
        do_reset();
        return;
      end
      d = (i < 6) ? 8'h55 : ((i == 6) ? 8'hD5 : 8'($urandom));
      if (abort_at >= 0 && i >= abort_at) x = X_IDLE;
      drive(d, 1'b1, (i == err_at), x);
    end
    if (abort_at == len) x = X_IDLE;
    drive(8'h00, 1'b0, 1'b0, x);
    repeat ($urandom_range(2, 6)) drive(8'h00, 1'b0, 1'b0, x);
  endtask

  // Scoreboard monitor: one comparison per output slot, sampled just after the edge.
  always @(posedge GTX_CLK) begin
    exp_t e;
    #1;
    if (!mr_main_reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.tx_code_group, bus.tx_is_k, bus.tx_even, bus.transmitting} === e) begin
        passed++;
      end else begin
        $display("FAIL cg slot %0d: got code=%02h k=%b even=%b tx=%b, want code=%02h k=%b even=%b tx=%b",
                 slot_no, bus.tx_code_group, bus.tx_is_k, bus.tx_even, bus.transmitting,
                 e.o, e.k, e.e, e.t);
      end
      slot_no++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.TXD   = 8'h00;
    bus.TX_EN = 1'b0;
    bus.TX_ER = 1'b0;
    bus.xmit  = X_IDLE;
    model_reset();
    repeat (2) @(negedge GTX_CLK);
    check_reset("reset_initial");
    release_reset();

    repeat (10) drive(8'h00, 1'b0, 1'b0, X_IDLE);
    repeat (19) drive(8'($urandom), 1'b0, 1'b0, X_CFG);
    repeat (6) drive(8'h00, 1'b0, 1'b0, X_IDLE);

    send_frame(12, -1, -1, -1);
    send_frame(14, 9, -1, -1);
    send_frame(14, -1, 10, -1);
    send_frame(12, -1, 12, -1);
    send_frame(14, -1, -1, 9);

    // TX_EN already high when DATA is selected: that frame must be ignored.
    repeat (3) drive(8'h55, 1'b1, 1'b0, X_IDLE);
    repeat (6) drive(8'h55, 1'b1, 1'b0, X_DATA);
    repeat (3) drive(8'h00, 1'b0, 1'b0, X_DATA);

    for (int it = 0; it < 50; it++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 5);
      len  = $urandom_range(8, 20);
      case (kind)
        0: repeat ($urandom_range(3, 13)) drive(8'($urandom), 1'b0, 1'b0, X_CFG);
        1: repeat ($urandom_range(2, 6)) drive(8'($urandom), 1'b0, 1'b0, 3'($urandom));
        2: send_frame(len, $urandom_range(7, len - 1), -1, -1);
        3: send_frame(len, -1, $urandom_range(3, len), -1);
        4: send_frame(len, -1, -1, $urandom_range(2, len - 1));
        default: send_frame(len, -1, -1, -1);
      endcase
    end
    repeat (4) drive(8'h00, 1'b0, 1'b0, X_IDLE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge GTX_CLK);
    #3;
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
